// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The HALT state only exists when FETCH_HALT_EN is defined.
package fetch_pkg;

    localparam int unsigned          INSTR_W    = 32;
    localparam logic [INSTR_W-1:0]   PC_STEP    = 32'd4;
    // csrrwi x0, 0, 31: program-end marker
    localparam logic [INSTR_W-1:0]   HALT_INSTR = 32'h000F_D073;

`ifdef FETCH_HALT_EN
    typedef enum logic [1:0] {StWaitLoad, StRun, StHalt} fetch_state_e;
`else
    typedef enum logic [1:0] {StWaitLoad, StRun} fetch_state_e;
`endif

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} between fetch and decode.
// Flush wins over push; a push while full is accepted only with a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [INSTR_W-1:0]     push_pc,
    input  logic [INSTR_W-1:0]     push_instr,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [INSTR_W-1:0]     head_pc,
    output logic [INSTR_W-1:0]     head_instr
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    head;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head       = mem_q[rd_ptr_q];
    assign head_pc    = head.pc;
    assign head_instr = head.instr;

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= '{pc: push_pc, instr: push_instr};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: waits for the loader, streams sequential reads
// from RESET_PC into a small FIFO, and handles PC redirects.
// Optional feature macro: FETCH_HALT_EN (stop fetching on the halt marker).
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load_done,
    output logic        imem_re,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

    localparam int unsigned       CntW         = $clog2(DEPTH) + 1;
    localparam int unsigned       OccW         = CntW + 1;
    localparam logic [INSTR_W-1:0] ResetPcAlign = RESET_PC & ~32'h3;

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic               inflight_q;
    logic [INSTR_W-1:0] inflight_pc_q;
    logic               redirect_take, pop, fifo_push, fifo_full, fifo_empty;
    logic               halt_hit, space_ok;
    logic [CntW-1:0]    fifo_count;
    logic [OccW-1:0]    occupancy;
    logic               unused_full;

    assign out_valid     = ~fifo_empty;
    assign pop           = out_valid & out_ready;
    assign redirect_take = redirect_valid & (state_q != StWaitLoad);
    // A response arriving in a redirect cycle belongs to the old path.
    assign fifo_push     = inflight_q & ~redirect_take;
    assign imem_addr     = pc_q;
    assign unused_full   = fifo_full;

`ifdef FETCH_HALT_EN
    assign halt_hit = fifo_push & (imem_rdata == HALT_INSTR);
`else
    assign halt_hit = 1'b0;
`endif

    // Entries that will occupy the FIFO after this edge, before any new issue.
    assign occupancy = OccW'(fifo_count) + OccW'(inflight_q) - OccW'(pop);
    assign space_ok  = (occupancy < OccW'(DEPTH));

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StWaitLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitLoad: if (load_done) state_d = StRun;
            StRun: begin
`ifdef FETCH_HALT_EN
                if (halt_hit) state_d = StHalt;
`endif
            end
`ifdef FETCH_HALT_EN
            StHalt: if (redirect_take) state_d = StRun;
`endif
            default: state_d = StWaitLoad;
        endcase
    end

    // FSM outputs: read strobe and halt indication.
    always_comb begin
        imem_re = 1'b0;
        halted  = 1'b0;
        if ((state_q == StRun) && !redirect_take && !halt_hit && space_ok) begin
            imem_re = 1'b1;
        end
`ifdef FETCH_HALT_EN
        halted = (state_q == StHalt);
`endif
    end

    // Fetch PC: redirect target, else advance on each issued read.
    always_comb begin
        pc_d = pc_q;
        if (redirect_take) begin
            pc_d = redirect_pc & ~32'h3;
        end else if (imem_re) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC and single outstanding-read tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q          <= ResetPcAlign;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= imem_re;
            if (imem_re) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (fifo_push),
        .push_pc    (inflight_pc_q),
        .push_instr (imem_rdata),
        .pop        (pop),
        .flush      (redirect_take),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for streaming plus hand
// sequences for load latency, halt, stalls, redirect, PC wrap and reset.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        load_done = 1'b0;
    logic        imem_re;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    logic [31:0] mem [64];

    int checks    = 0;
    int failures  = 0;
    int ovf_errs  = 0;

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC (32'h0),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .load_done      (load_done),
        .imem_re        (imem_re),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    // Synchronous-read instruction memory model.
    always @(posedge clk) begin
        if (imem_re) imem_rdata <= mem[imem_addr[7:2]];
    end

    // Overflow / read-space monitor.
    always @(negedge clk) begin
        if (rstn) begin
            if (dut.fifo_push && dut.fifo_full && !dut.pop) begin
                ovf_errs++;
                $display("FAIL fifo_overflow at %0t: push while full", $time);
            end
            if (int'(dut.fifo_count) + int'(dut.inflight_q) > int'(DEPTH)) begin
                ovf_errs++;
                $display("FAIL read_space at %0t: count=%0d inflight=%0d", $time,
                         dut.fifo_count, dut.inflight_q);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] hold_pc, hold_instr;
        logic        hold;
        int          transfers;

        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[7] = HALT_INSTR;
        for (int i = 0; i < 8; i++) begin
            tbl[i].ready     = 1'b1;
            tbl[i].exp_valid = 1'b1;
            tbl[i].exp_pc    = 32'(i * 4);
            tbl[i].exp_instr = (i == 7) ? HALT_INSTR : 32'h1000_0000 + i;
        end

        // Asynchronous reset before the first clock edge.
        #1 rstn = 1'b0;
        #2;
        chk("rst_imem_re", imem_re, 0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_halted", halted, 0);
        next_cycle();
        next_cycle();
        rstn = 1'b1;

        // Waiting for load: no reads, redirect ignored.
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            redirect_valid = (i == 4);
            redirect_pc    = 32'h0000_0100;
            settle();
            chk("wait_imem_re", imem_re, 0);
            chk("wait_out_valid", out_valid, 0);
        end
        next_cycle();
        redirect_valid = 1'b0;
        load_done      = 1'b1;
        out_ready      = 1'b1;
        settle();
        chk("load_pre_re", imem_re, 0);
        next_cycle();
        settle();
        chk("load_first_re", imem_re, 1);
        chk("load_first_addr", imem_addr, 32'h0);
        chk("load_first_valid", out_valid, 0);
        next_cycle();
        settle();
        chk("load_second_addr", imem_addr, 32'h4);
        chk("load_second_valid", out_valid, 0);
        next_cycle();

        // Sequential streaming from the vector table.
        for (int i = 0; i < 8; i++) begin
            out_ready = tbl[i].ready;
            settle();
            chk($sformatf("stream_valid[%0d]", i), out_valid, tbl[i].exp_valid);
            chk($sformatf("stream_pc[%0d]", i), out_pc, tbl[i].exp_pc);
            chk($sformatf("stream_instr[%0d]", i), out_instr, tbl[i].exp_instr);
            if (i == 7) begin
`ifdef FETCH_HALT_EN
                chk("halt_set", halted, 1);
                chk("halt_no_read", imem_re, 0);
`else
                chk("nohalt_halted", halted, 0);
                chk("nohalt_read_addr", imem_addr, 32'd36);
`endif
            end
            next_cycle();
        end
        settle();
`ifdef FETCH_HALT_EN
        chk("halt_drained", out_valid, 0);
        chk("halt_no_read2", imem_re, 0);
        next_cycle();
        settle();
        chk("halt_no_read3", imem_re, 0);
        chk("halt_held", halted, 1);
`else
        chk("nohalt_next_pc", out_pc, 32'd32);
        chk("nohalt_next_instr", out_instr, 32'h1000_0008);
`endif
        next_cycle();
        mem[7] = 32'h1000_0007;

        // Redirect to 0 (resumes from HALT when enabled).
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        settle();
        chk("redir0_no_issue", imem_re, 0);
        next_cycle();
        redirect_valid = 1'b0;
        settle();
        chk("redir0_re", imem_re, 1);
        chk("redir0_addr", imem_addr, 32'h0);
        chk("redir0_halted", halted, 0);
        chk("redir0_flushed", out_valid, 0);
        next_cycle();
        settle();
        chk("redir0_valid_lat", out_valid, 0);
        next_cycle();
        settle();
        chk("redir0_out_valid", out_valid, 1);
        chk("redir0_out_pc", out_pc, 32'h0);

        // Ready toggling: in-order delivery, stable while stalled.
        exp_pc    = 32'h0;
        hold      = 1'b0;
        hold_pc   = '0;
        hold_instr = '0;
        transfers = 0;
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 3 != 2);
            settle();
            if (hold) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_pc", out_pc, hold_pc);
                chk("stall_instr", out_instr, hold_instr);
            end
            hold = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    chk("toggle_pc", out_pc, exp_pc);
                    chk("toggle_instr", out_instr, mem[exp_pc[7:2]]);
                    exp_pc = exp_pc + 32'd4;
                    transfers++;
                end else begin
                    hold       = 1'b1;
                    hold_pc    = out_pc;
                    hold_instr = out_instr;
                end
            end
            next_cycle();
        end
        chk("toggle_progress", (transfers >= 20), 1);

        // Build up 2 buffered + 1 inflight, then redirect to 0x12.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        settle();
        next_cycle();
        redirect_valid = 1'b0;
        settle();
        chk("fill_addr", imem_addr, 32'h40);
        next_cycle();
        next_cycle();
        next_cycle();
        settle();
        chk("fill_count", dut.fifo_count, 2);
        chk("fill_inflight", dut.inflight_q, 1);
        chk("fill_head", out_pc, 32'h40);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0012;
        #1;
        chk("redir12_no_issue", imem_re, 0);
        next_cycle();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        settle();
        chk("redir12_flushed", out_valid, 0);
        chk("redir12_addr", imem_addr, 32'h10);
        next_cycle();
        settle();
        chk("redir12_no_stale", out_valid, 0);
        next_cycle();
        settle();
        chk("redir12_valid", out_valid, 1);
        chk("redir12_pc", out_pc, 32'h10);
        chk("redir12_instr", out_instr, 32'h1000_0004);
        next_cycle();
        settle();
        chk("redir12_pc2", out_pc, 32'h14);
        next_cycle();
        settle();
        chk("redir12_pc3", out_pc, 32'h18);
        next_cycle();

        // PC wrap from 0xFFFF_FFF8.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        settle();
        next_cycle();
        redirect_valid = 1'b0;
        settle();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        next_cycle();
        settle();
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        next_cycle();
        settle();
        chk("wrap_addr2", imem_addr, 32'h0);
        chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        chk("wrap_instr0", out_instr, 32'h1000_003E);
        next_cycle();
        settle();
        chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        chk("wrap_instr1", out_instr, 32'h1000_003F);
        next_cycle();
        settle();
        chk("wrap_pc2", out_pc, 32'h0);
        chk("wrap_instr2", out_instr, 32'h1000_0000);

        // Asynchronous reset mid-stream.
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_re", imem_re, 0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_pc", out_pc, 32'h0);
        chk("mid_rst_instr", out_instr, 32'h0);
        chk("mid_rst_halted", halted, 0);
        next_cycle();
        rstn = 1'b1;
        settle();
        chk("mid_rst_wait_load", imem_re, 0);
        next_cycle();
        settle();
        chk("mid_rst_restart_re", imem_re, 1);
        chk("mid_rst_restart_addr", imem_addr, 32'h0);

        next_cycle();
        next_cycle();
        chk("no_overflow", ovf_errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
